debug_io_hub: RTL and testbench

- Parametrised successor to the fixed 4-channel debug I/O manager.
- Conditions board buttons: 2-flop sync, debounce, edge detect into a one-cycle `step` pulse.
- Generates a stretched core reset and exposes NUM_CH 32-bit debug channels.
- Shows the selected channel on the 8-digit seven-segment display, with freeze and free-run modes; sits between the core and the board GPIO.

---
 rtl/debug_io_hub_pkg.sv | 45 ++++
 rtl/debug_io_hub_if.sv | 28 ++
 rtl/debug_io_hub_btn_debounce.sv | 49 ++++
 rtl/debug_io_hub.sv | 113 +++++++++++
 tb/tb_debug_io_hub.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/debug_io_hub_pkg.sv
// rtl/debug_io_hub_pkg.sv - shared display constants and seven-segment decoder
package debug_io_pkg;
  localparam int DIGITS = 8;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always kept dark.
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  function automatic logic [7:0] hex7seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction
endpackage

// File: rtl/debug_io_hub_if.sv
// rtl/debug_io_hub_if.sv - board-side and core-side signals of the debug hub
interface debug_io_hub_if #(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 4
);
  import debug_io_pkg::*;

  logic [4:0]          button;
  logic [SEL_W-1:0]    sel;
  logic                freeze;
  logic                run;
  logic [NUM_CH*32-1:0] debug_in;
  logic                step;
  logic                core_rst;
  logic [7:0]          num_csn;
  logic [DIGITS-1:0]   num_an;
  logic [15:0]         led;

  modport master (
    output button, sel, freeze, run, debug_in,
    input  step, core_rst, num_csn, num_an, led
  );

  modport slave (
    input  button, sel, freeze, run, debug_in,
    output step, core_rst, num_csn, num_an, led
  );
endinterface

// File: rtl/debug_io_hub_btn_debounce.sv
// rtl/debug_io_hub_btn_debounce.sv - button synchroniser, debouncer and rising-edge pulse
module btn_debounce #(
  parameter int DEB_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  // The counter only runs while the synced sample disagrees with the accepted level.
  always_comb begin
    sync_d  = {sync_q[0], raw};
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
endmodule

// File: rtl/debug_io_hub.sv
// rtl/debug_io_hub.sv - button conditioning, core reset stretch, channel capture and 7-seg scan
module debug_io_hub
  import debug_io_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int SEL_W      = 4,
  parameter int DEB_CYCLES = 20000,
  parameter int RST_HOLD   = 16,
  parameter int SCAN_DIV   = 50000
) (
  input logic clk,
  input logic reset,
  debug_io_hub_if.slave io
);
  localparam int RST_W = $clog2(RST_HOLD + 1);
  localparam int DIV_W = $clog2(SCAN_DIV + 1);

  logic lvl0, rise0, lvl1, rise1;
  logic unused_buttons;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_step (
    .clk(clk), .reset(reset), .raw(io.button[0]), .level(lvl0), .rise(rise0)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_rst (
    .clk(clk), .reset(reset), .raw(io.button[1]), .level(lvl1), .rise(rise1)
  );

  assign unused_buttons = ^{io.button[4:2], lvl1};

  logic             step_q, step_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       csn_q, csn_d;
  logic [15:0]      led_q, led_d;
  logic [31:0]      ch_val;
  logic             oor;
  logic             core_rst;

  assign oor      = ({1'b0, io.sel} >= (SEL_W + 1)'(NUM_CH));
  assign core_rst = (rst_cnt_q != '0);

  always_comb begin
    ch_val = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (io.sel == SEL_W'(k)) ch_val = io.debug_in[k*32 +: 32];
    end
  end

  always_comb begin
    step_d = io.run ? 1'b1 : rise0;

    rst_cnt_d = rst_cnt_q;
    if (rise1) begin
      rst_cnt_d = RST_W'(RST_HOLD);
    end else if (rst_cnt_q != '0) begin
      rst_cnt_d = rst_cnt_q - 1'b1;
    end

    shadow_d = shadow_q;
    if (!io.freeze) shadow_d = oor ? 32'h0 : ch_val;

    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = idx_q + 1'b1;
    end

    // Digit enable and segments are both derived from idx_q so they switch together.
    an_d  = ~({{(DIGITS - 1){1'b0}}, 1'b1} << idx_q);
    csn_d = hex7seg(shadow_q[{idx_q, 2'b00} +: 4]);

    led_d            = '0;
    led_d[SEL_W-1:0] = io.sel;
    led_d[11]        = io.freeze;
    led_d[12]        = io.run;
    led_d[13]        = core_rst;
    led_d[14]        = lvl0;
    led_d[15]        = oor;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q    <= 1'b0;
      rst_cnt_q <= RST_W'(RST_HOLD);
      shadow_q  <= '0;
      div_q     <= '0;
      idx_q     <= '0;
      an_q      <= 8'hFE;
      csn_q     <= 8'hFF;
      led_q     <= '0;
    end else begin
      step_q    <= step_d;
      rst_cnt_q <= rst_cnt_d;
      shadow_q  <= shadow_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      csn_q     <= csn_d;
      led_q     <= led_d;
    end
  end

  assign io.step     = step_q;
  assign io.core_rst = core_rst;
  assign io.num_an   = an_q;
  assign io.num_csn  = csn_q;
  assign io.led      = led_q;
endmodule

// File: tb/tb_debug_io_hub.sv
// tb/tb_debug_io_hub.sv - randomized and directed bench for debug_io_hub against a cycle reference model
module tb_debug_io_hub;
  localparam int NUM_CH   = 8;
  localparam int SEL_W    = 4;
  localparam int DEB      = 4;
  localparam int RST_HOLD = 16;
  localparam int SCAN_DIV = 3;
  localparam int PRESS_AT = 5;

  // Active-high gfedcba shapes of 0..F.
  localparam logic [6:0] SHAPE [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  debug_io_hub_if #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus ();

  debug_io_hub #(
    .NUM_CH(NUM_CH), .SEL_W(SEL_W), .DEB_CYCLES(DEB), .RST_HOLD(RST_HOLD), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .reset(reset), .io(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_exp(input logic [3:0] n);
    return {1'b1, ~SHAPE[n]};
  endfunction

  // Reference model state
  logic [31:0] m_shadow;
  int          m_cnt, m_div, m_idx;
  int          m_streak [2];
  logic        m_lvl [2], m_pend [2], m_dl0 [2], m_dl1 [2];
  logic        e_step, e_core;
  logic [7:0]  e_an, e_csn;
  logic [15:0] e_led;

  task automatic model_edge();
    logic synced;
    if (reset) begin
      m_shadow = '0; m_cnt = RST_HOLD; m_div = 0; m_idx = 0;
      for (int b = 0; b < 2; b++) begin
        m_streak[b] = 0; m_lvl[b] = 0; m_pend[b] = 0; m_dl0[b] = 0; m_dl1[b] = 0;
      end
      e_step = 0; e_an = 8'hFE; e_csn = 8'hFF; e_led = '0;
    end else begin
      e_led = '0;
      e_led[3:0] = bus.sel;
      e_led[11] = bus.freeze;
      e_led[12] = bus.run;
      e_led[13] = (m_cnt != 0);
      e_led[14] = m_lvl[0];
      e_led[15] = (int'(bus.sel) >= NUM_CH);
      e_an  = ~(8'd1 << m_idx);
      e_csn = seg_exp(m_shadow[4*m_idx +: 4]);
      e_step = bus.run ? 1'b1 : m_pend[0];
      if (m_pend[1]) m_cnt = RST_HOLD;
      else if (m_cnt > 0) m_cnt--;
      if (!bus.freeze)
        m_shadow = (int'(bus.sel) < NUM_CH) ? bus.debug_in[int'(bus.sel)*32 +: 32] : 32'h0;
      m_div++;
      if (m_div == SCAN_DIV) begin
        m_div = 0;
        m_idx = (m_idx + 1) % 8;
      end
      for (int b = 0; b < 2; b++) begin
        synced = m_dl1[b];
        m_pend[b] = 0;
        if (synced != m_lvl[b]) begin
          m_streak[b]++;
          if (m_streak[b] == DEB) begin
            m_lvl[b] = ~m_lvl[b];
            m_streak[b] = 0;
            m_pend[b] = m_lvl[b];
          end
        end else begin
          m_streak[b] = 0;
        end
        m_dl1[b] = m_dl0[b];
        m_dl0[b] = bus.button[b];
      end
    end
    e_core = (m_cnt != 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_edge();
    chk("step", bus.step, e_step);
    chk("core_rst", bus.core_rst, e_core);
    chk("num_an", bus.num_an, e_an);
    chk("num_csn", bus.num_csn, e_csn);
    chk("led", bus.led, e_led);
  endtask

  // Collects the segments shown for each digit over one full scan and compares them.
  task automatic scan_check(input string tag, input logic [31:0] val);
    logic [7:0] got [8];
    for (int i = 0; i < 8; i++) got[i] = 8'h00;
    for (int c = 0; c < 8 * SCAN_DIV + 2; c++) begin
      cyc();
      for (int i = 0; i < 8; i++)
        if (bus.num_an == ~(8'd1 << i)) got[i] = bus.num_csn;
    end
    for (int i = 0; i < 8; i++) chk(tag, got[i], seg_exp(val[4*i +: 4]));
  endtask

  int highs, pulses, pulse_at;
  logic [31:0] ref_val;

  initial begin
    reset = 1'b1;
    bus.button = '0; bus.sel = '0; bus.freeze = 0; bus.run = 0;
    for (int k = 0; k < NUM_CH; k++) bus.debug_in[k*32 +: 32] = $urandom;

    for (int i = 0; i < 3; i++) cyc();
    chk("rst_an", bus.num_an, 8'hFE);
    chk("rst_step", bus.step, 1'b0);
    highs = int'(bus.core_rst);
    reset = 1'b0;
    for (int i = 0; i < RST_HOLD + 6; i++) begin
      cyc();
      highs += int'(bus.core_rst);
    end
    chk("rst_hold_len", highs, RST_HOLD);

    // Bouncing step button, then a clean hold
    for (int i = 0; i < 10; i++) begin
      bus.button[0] = ((i / 2) % 2) == 1;
      cyc();
    end
    bus.button[0] = 1'b1;
    pulses = 0; pulse_at = -1;
    for (int j = 0; j < 14; j++) begin
      cyc();
      if (bus.step) begin
        pulses++;
        pulse_at = j;
      end
    end
    chk("bounce_pulses", pulses, 1);
    chk("bounce_latency", pulse_at, DEB + 2);
    bus.button[0] = 1'b0;
    for (int i = 0; i < 10; i++) cyc();

    // Free-run mode
    bus.run = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    bus.button[0] = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    bus.button[0] = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("run_step", bus.step, 1'b1);
    bus.run = 1'b0;
    cyc();
    chk("run_off_step", bus.step, 1'b0);

    // Capture and freeze
    ref_val = 32'h1234ABCD;
    bus.debug_in[3*32 +: 32] = ref_val;
    bus.sel = 4'd3;
    cyc(); cyc();
    scan_check("scan_live", ref_val);
    bus.freeze = 1'b1;
    cyc();
    bus.debug_in[3*32 +: 32] = 32'h0F0F_5A5A ^ $urandom;
    scan_check("scan_frozen", ref_val);

    // Out-of-range select
    bus.freeze = 1'b0;
    bus.sel = 4'd9;
    cyc(); cyc();
    chk("oor_led", bus.led[15], 1'b1);
    scan_check("scan_oor", 32'h0);

    // Reset, then a core-reset press landing mid-countdown
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    highs = int'(bus.core_rst);
    for (int i = 0; i < PRESS_AT; i++) begin
      cyc();
      highs += int'(bus.core_rst);
    end
    bus.button[1] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      highs += int'(bus.core_rst);
    end
    chk("reload_len", highs, PRESS_AT + DEB + 3 + RST_HOLD);
    bus.button[1] = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    reset = 1'b1;
    cyc();
    chk("midscan_an", bus.num_an, 8'hFE);
    chk("midscan_csn", bus.num_csn, 8'hFF);
    reset = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 11) == 0) bus.button[0] = ~bus.button[0];
      if ($urandom_range(0, 15) == 0) bus.button[1] = ~bus.button[1];
      if ($urandom_range(0, 7) == 0) bus.button[4:2] = 3'($urandom);
      if ($urandom_range(0, 19) == 0) bus.sel = 4'($urandom);
      if ($urandom_range(0, 29) == 0) bus.freeze = ~bus.freeze;
      if ($urandom_range(0, 49) == 0) bus.run = ~bus.run;
      bus.debug_in[$urandom_range(0, NUM_CH - 1)*32 +: 32] = $urandom;
      reset = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
